// File: rtl/alu_share_ctrl_if.sv
// Bundle between requesters, the shared-ALU controller, the ALU and the result consumer.
// The controller takes the slave view; the environment driving it takes the master view.
interface alu_share_ctrl_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [5*NUM_REQ-1:0]  req_sel;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_zero;
  logic                  rsp_err;

  logic [31:0]           alu_a;
  logic [31:0]           alu_b;
  logic [4:0]            alu_sel;
  logic                  alu_start;
  logic [31:0]           alu_out;
  logic                  alu_zero;
  logic                  alu_complete;

  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready, alu_out, alu_zero, alu_complete,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
           alu_a, alu_b, alu_sel, alu_start, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready, alu_out, alu_zero, alu_complete,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err,
           alu_a, alu_b, alu_sel, alu_start, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one multi-cycle ALU among NUM_REQ requesters, one op in flight,
// with a completion timeout and a valid/ready result channel tagged by requester id.
module alu_share_ctrl #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] scan_idx;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [31:0]    gnt_a, gnt_b;
  logic [4:0]     gnt_sel;
  logic [CW-1:0]  wait_cnt;
  logic [31:0]    a_q, b_q, data_q;
  logic [4:0]     sel_q;
  logic [IDW-1:0] id_q;
  logic           zero_q, err_q;
  logic           timeout;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_idx;
      end
    end
  end

  always_comb begin
    gnt_a   = '0;
    gnt_b   = '0;
    gnt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        gnt_a   = bus.req_a[32*i +: 32];
        gnt_b   = bus.req_b[32*i +: 32];
        gnt_sel = bus.req_sel[5*i +: 5];
      end
    end
  end

  assign timeout = (wait_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.alu_complete || timeout) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are forced low while rst is high so outputs read 0 as soon as reset hits.
  always_comb begin
    bus.req_ready = '0;
    bus.alu_start = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    if (gnt_vld) bus.req_ready[gnt_id] = 1'b1;
        ISSUE:   begin bus.alu_start = 1'b1; bus.busy = 1'b1; end
        WAIT:    bus.busy = 1'b1;
        RESP:    begin bus.rsp_valid = 1'b1; bus.busy = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      id_q     <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          a_q    <= gnt_a;
          b_q    <= gnt_b;
          sel_q  <= gnt_sel;
          id_q   <= gnt_id;
          rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (bus.alu_complete) begin
            data_q <= bus.alu_out;
            zero_q <= bus.alu_zero;
            err_q  <= 1'b0;
          end else if (timeout) begin
            data_q <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_sel  = sel_q;
  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_zero = zero_q;
  assign bus.rsp_err  = err_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed and randomized transactions against an op-level model: round-robin grant order,
// ALU result function, response timing and the timeout rule.
module tb_alu_share_ctrl;
  localparam int NR = 3;
  localparam int TO = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.NUM_REQ(NR)) bus ();

  alu_share_ctrl #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int model_ptr = 0;
  logic [31:0] op_a [NR];
  logic [31:0] op_b [NR];
  logic [4:0]  op_sel [NR];

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    case (s)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return a * b;
      5'd6:    return (b == 0) ? 32'd0 : a / b;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One full op: offer vld, let the ALU complete after lat WAIT cycles (never if lat >= TO),
  // then hold the response for hold cycles before taking it.
  task automatic transact(input logic [NR-1:0] vld, input int lat, input int hold);
    int g;
    int w;
    bit done;
    logic [31:0] ea, eb, ed, res;
    logic [4:0] es;
    logic ez, ee;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      bus.req_a[32*i +: 32] = op_a[i];
      bus.req_b[32*i +: 32] = op_b[i];
      bus.req_sel[5*i +: 5] = op_sel[i];
    end
    bus.req_valid = vld;
    #1;
    if (vld == '0) begin
      chk("idle_no_ready", 32'(bus.req_ready), 32'd0);
      chk("idle_not_busy", 32'(bus.busy), 32'd0);
      return;
    end
    g = -1;
    for (int k = 0; k < NR; k++)
      if (g < 0 && vld[(model_ptr + k) % NR]) g = (model_ptr + k) % NR;
    chk("grant", 32'(bus.req_ready), 32'(1 << g));
    model_ptr = (g + 1) % NR;
    ea = op_a[g];
    eb = op_b[g];
    es = op_sel[g];

    @(negedge clk);
    chk("issue_start", 32'(bus.alu_start), 32'd1);
    chk("issue_a", bus.alu_a, ea);
    chk("issue_b", bus.alu_b, eb);
    chk("issue_sel", 32'(bus.alu_sel), 32'(es));
    chk("issue_no_ready", 32'(bus.req_ready), 32'd0);

    w = 0;
    done = 1'b0;
    ed = '0; ez = 1'b0; ee = 1'b0;
    while (!done) begin
      @(negedge clk);
      chk("wait_start_low", 32'(bus.alu_start), 32'd0);
      chk("wait_a_stable", bus.alu_a, ea);
      chk("wait_sel_stable", 32'(bus.alu_sel), 32'(es));
      chk("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("wait_no_ready", 32'(bus.req_ready), 32'd0);
      if (w == lat) begin
        res = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
        bus.alu_out = res;
        bus.alu_zero = (res == 0);
        bus.alu_complete = 1'b1;
        ed = alu_fn(ea, eb, es);
        ez = (ed == 0);
        ee = 1'b0;
        done = 1'b1;
      end else if (w == TO - 1) begin
        ed = '0; ez = 1'b0; ee = 1'b1;
        done = 1'b1;
      end else begin
        bus.alu_out = $urandom;
        bus.alu_zero = 1'($urandom);
      end
      w++;
    end

    @(negedge clk);
    bus.alu_complete = 1'b0;
    bus.alu_out = $urandom;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_id", 32'(bus.rsp_id), 32'(g));
      chk("rsp_data", bus.rsp_data, ed);
      chk("rsp_zero", 32'(bus.rsp_zero), 32'(ez));
      chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
      chk("rsp_no_ready", 32'(bus.req_ready), 32'd0);
      if (h == hold) bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    chk("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    chk("back_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int r;
    int lat;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sel = '0;
    bus.rsp_ready = 1'b0;
    bus.alu_out = '0;
    bus.alu_zero = 1'b0;
    bus.alu_complete = 1'b0;
    for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; op_sel[i] = '0; end

    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_start", 32'(bus.alu_start), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single ADD from requester 0
    op_a[0] = 32'd5; op_b[0] = 32'd3; op_sel[0] = 5'd0;
    transact(3'b001, 0, 0);

    // two contending requesters: SUB to zero and ADD
    op_a[0] = 32'd5; op_b[0] = 32'd5; op_sel[0] = 5'd1;
    op_a[1] = 32'd2; op_b[1] = 32'd3; op_sel[1] = 5'd0;
    for (int n = 0; n < 4; n++) transact(3'b011, 0, 0);

    // long DIV, then timeout, then completion exactly in the timeout cycle
    op_a[0] = 32'd6; op_b[0] = 32'd2; op_sel[0] = 5'd6;
    transact(3'b001, 10, 0);
    op_a[1] = 32'd77; op_b[1] = 32'd1; op_sel[1] = 5'd0;
    transact(3'b010, 1000, 0);
    transact(3'b010, 0, 0);
    transact(3'b100, TO - 1, 0);

    // consumer stalls the response
    transact(3'b111, 2, 5);

    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    bus.req_valid = 3'b011;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("arst_alu_a", bus.alu_a, 32'd0);
    chk("arst_alu_sel", 32'(bus.alu_sel), 32'd0);
    chk("arst_rsp_id", 32'(bus.rsp_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    model_ptr = 0;
    transact(3'b111, 0, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NR; i++) begin
        op_a[i] = $urandom;
        op_b[i] = (n % 5 == 0) ? op_a[i] : 32'($urandom);
        op_sel[i] = 5'($urandom_range(0, 7));
      end
      r = $urandom_range(0, 9);
      if (r < 7)       lat = $urandom_range(0, 3);
      else if (r == 7) lat = TO - 1;
      else if (r == 8) lat = TO + 2;
      else             lat = $urandom_range(4, TO - 2);
      transact(3'($urandom_range(0, 7)), lat, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
